// File: rtl/ntt_idx_gen_if.sv
// Handshake/bus bundle for the NTT index generator: sweep request in, index stream out.
interface ntt_idx_gen_if #(parameter int D_WIDTH = 12);
  logic               start;
  logic [D_WIDTH-1:0] l_in;
  logic               hold;
  logic [D_WIDTH-1:0] input_idx;
  logic               BitRev_enable;
  logic [D_WIDTH-1:0] l;
  logic               idx_last;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, l_in, hold,
    input  input_idx, BitRev_enable, l, idx_last, busy, done, err
  );

  modport slave (
    input  start, l_in, hold,
    output input_idx, BitRev_enable, l, idx_last, busy, done, err
  );
endinterface

// File: rtl/ntt_idx_gen.sv
// NTT index sweep generator: emits 0..2^(RADIX_K1*l)-1 to the bit-reversal stage,
// stallable by hold, with done/err pulses and a latched digit count.
module ntt_idx_gen #(
  parameter int D_WIDTH  = 12,
  parameter int RADIX_K1 = 2
) (
  input logic         clk,
  input logic         rst,
  ntt_idx_gen_if.slave bus
);
  // Wide enough that RADIX_K1*l_in can never wrap before the range check.
  localparam int WW = D_WIDTH + 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [D_WIDTH-1:0] idx_q, l_q, last_q;
  logic               err_q;

  logic [WW-1:0]      w_calc, shamt;
  logic               w_ok;
  logic [D_WIDTH-1:0] ones, last_next;
  logic               en, at_last;

  assign w_calc    = WW'(RADIX_K1) * WW'(bus.l_in);
  assign w_ok      = (w_calc != '0) && (w_calc <= WW'(D_WIDTH));
  assign ones      = '1;
  assign shamt     = WW'(D_WIDTH) - w_calc;
  // Terminal index N-1 as a right-aligned mask; only meaningful when w_ok.
  assign last_next = ones >> shamt;
  assign at_last   = (idx_q == last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start && w_ok) state_n = RUN;
      RUN:     if (!bus.hold && at_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    en       = (state == RUN) && !bus.hold;
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      l_q    <= '0;
      last_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (w_ok) begin
              l_q    <= bus.l_in;
              last_q <= last_next;
              idx_q  <= '0;
            end else begin
              err_q  <= 1'b1;
            end
          end
        end
        // Saturates at N-1: the FSM leaves RUN on that same edge.
        RUN:     if (!bus.hold && !at_last) idx_q <= idx_q + 1'b1;
        DONE:    idx_q <= '0;
        default: idx_q <= '0;
      endcase
    end
  end

  assign bus.input_idx     = idx_q;
  assign bus.BitRev_enable = en;
  assign bus.l             = l_q;
  assign bus.idx_last      = en && at_last;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_ntt_idx_gen.sv
// Bench for ntt_idx_gen: vector table of sweeps, hand sequences for reset,
// randomized sweeps checked against an index-stream model.
module tb_ntt_idx_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   prev_l = 0;

  ntt_idx_gen_if #(.D_WIDTH(12)) bus();
  ntt_idx_gen #(.D_WIDTH(12), .RADIX_K1(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int l_in;
    int hold_at;
    int hold_len;
    int restart_at;
    bit exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: an accepted sweep yields every index 0..N-1 once, in order,
  // skipping only held cycles; done follows the last index by one cycle.
  task automatic run_sweep(input int lv, input int hold_at, input int hold_len,
                           input int restart_at, input int rnd_pct, input bit exp_err);
    int n, exp_idx, hc, cyc;
    bit fin, h, rs, restarted;
    bus.start = 1'b1;
    bus.l_in  = 12'(lv);
    bus.hold  = 1'b0;
    tick();
    bus.start = 1'b0;
    if (exp_err) begin
      chk("err_pulse", 32'(bus.err), 1);
      chk("err_busy", 32'(bus.busy), 0);
      chk("err_l_kept", 32'(bus.l), 32'(prev_l));
      chk("err_en", 32'(bus.BitRev_enable), 0);
      tick();
      chk("err_one_cycle", 32'(bus.err), 0);
      chk("err_idle", 32'(bus.busy), 0);
      return;
    end
    n = 1 << (2 * lv);
    exp_idx = 0; hc = 0; cyc = 0; fin = 0; restarted = 0;
    while (!fin && cyc < 3 * n + 50) begin
      h = 1'b0;
      if (exp_idx == hold_at && hc < hold_len) begin
        h = 1'b1;
        hc++;
      end else if (rnd_pct > 0 && $urandom_range(0, 99) < rnd_pct) begin
        h = 1'b1;
      end
      bus.hold = h;
      rs = (exp_idx == restart_at) && !h && !restarted;
      if (rs) begin
        bus.start = 1'b1;
        bus.l_in  = 12'd3;
        restarted = 1'b1;
      end
      #1;
      chk("run_busy", 32'(bus.busy), 1);
      chk("run_en", 32'(bus.BitRev_enable), 32'(!h));
      chk("run_idx", 32'(bus.input_idx), 32'(exp_idx));
      chk("run_last", 32'(bus.idx_last), 32'(!h && exp_idx == n - 1));
      chk("run_err", 32'(bus.err), 0);
      chk("run_l", 32'(bus.l), 32'(lv));
      chk("run_done", 32'(bus.done), 0);
      tick();
      bus.start = 1'b0;
      bus.l_in  = 12'(lv);
      cyc++;
      if (!h) begin
        if (exp_idx == n - 1) fin = 1'b1;
        else exp_idx++;
      end
    end
    if (!fin) chk("sweep_timeout", 0, 1);
    bus.hold = 1'($urandom_range(0, 1));
    #1;
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_busy", 32'(bus.busy), 0);
    chk("done_en", 32'(bus.BitRev_enable), 0);
    chk("done_last", 32'(bus.idx_last), 0);
    chk("done_err", 32'(bus.err), 0);
    tick();
    bus.hold = 1'b0;
    #1;
    chk("after_done", 32'(bus.done), 0);
    chk("after_busy", 32'(bus.busy), 0);
    chk("after_idx", 32'(bus.input_idx), 0);
    chk("after_l", 32'(bus.l), 32'(lv));
    prev_l = lv;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    int v;
    vecs[0] = '{2, -1, 0, -1, 1'b0};  // plain 16-index sweep
    vecs[1] = '{2,  5, 3, -1, 1'b0};  // 3-cycle stall at index 5
    vecs[2] = '{0, -1, 0, -1, 1'b1};  // W=0 rejected
    vecs[3] = '{7, -1, 0, -1, 1'b1};  // W=14 rejected
    vecs[4] = '{2, -1, 0,  8, 1'b0};  // start re-asserted mid-sweep
    vecs[5] = '{1,  0, 2, -1, 1'b0};  // stall on the very first index
    vecs[6] = '{6, -1, 0, -1, 1'b0};  // full-width sweep, 4096 indices
    vecs[7] = '{3,  63, 1, -1, 1'b0}; // stall on the terminal index

    bus.start = 1'b0;
    bus.l_in  = '0;
    bus.hold  = 1'b0;
    #3;
    chk("rst_idx", 32'(bus.input_idx), 0);
    chk("rst_l", 32'(bus.l), 0);
    chk("rst_en", 32'(bus.BitRev_enable), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      run_sweep(vecs[i].l_in, vecs[i].hold_at, vecs[i].hold_len,
                vecs[i].restart_at, 0, vecs[i].exp_err);

    // Asynchronous reset in the middle of a sweep.
    bus.start = 1'b1;
    bus.l_in  = 12'd2;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    chk("pre_rst_idx", 32'(bus.input_idx), 9);
    #2 rst = 1'b1;
    #1;
    chk("arst_idx", 32'(bus.input_idx), 0);
    chk("arst_l", 32'(bus.l), 0);
    chk("arst_en", 32'(bus.BitRev_enable), 0);
    chk("arst_last", 32'(bus.idx_last), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_err", 32'(bus.err), 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("no_resume_busy", 32'(bus.busy), 0);
    chk("no_resume_idx", 32'(bus.input_idx), 0);
    prev_l = 0;
    run_sweep(1, -1, 0, -1, 0, 1'b0);

    // Randomized sweeps with random stalls.
    for (int i = 0; i < 20; i++) begin
      v = $urandom_range(0, 6);
      if (v == 6) v = 7;
      run_sweep(v, -1, 0, ($urandom_range(0, 1) != 0) ? 1 : -1, 25,
                (2 * v == 0) || (2 * v > 12));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ntt_idx_gen.md
NTT_IDX_GEN -- requirements
Module: ntt_idx_gen

Interface
REQ-001 SHALL have parameter D_WIDTH, default 12: width of the index and digit-count buses.
REQ-002 SHALL have parameter RADIX_K1, default 2: index bits per radix digit (radix-4).
REQ-003 SHALL have port clk, input, 1: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request to begin one index sweep.
REQ-006 SHALL have port l_in, input, D_WIDTH: radix-digit count for the sweep.
REQ-007 SHALL have port hold, input, 1: downstream stall; freezes the sweep.
REQ-008 SHALL have port input_idx, output, D_WIDTH: index presented to the bit-reversal stage.
REQ-009 SHALL have port BitRev_enable, output, 1: input_idx is valid this cycle.
REQ-010 SHALL have port l, output, D_WIDTH: latched digit count, held stable for the whole sweep.
REQ-011 SHALL have port idx_last, output, 1: the current valid index is N-1.
REQ-012 SHALL have port busy, output, 1: high in RUN.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when the sweep completes.
REQ-014 SHALL have port err, output, 1: one-cycle pulse when a start is rejected.

Function
REQ-015 SHALL use the states IDLE, RUN and DONE.
REQ-016 SHALL define W = RADIX_K1*l_in and N = 2^W, computed at the start edge.
REQ-017 SHALL, in IDLE with start=1 and 1 <= W <= D_WIDTH, latch l <= l_in, set input_idx <= 0 and enter RUN.
REQ-018 SHALL, in IDLE with start=1 and W=0 or W>D_WIDTH, pulse err for one cycle and remain in IDLE with l unchanged.
REQ-019 SHALL drive BitRev_enable = (state==RUN) & ~hold, so the first valid index appears in the cycle after the start edge.
REQ-020 SHALL, in RUN with hold=0, advance input_idx by 1 per cycle; with hold=1, freeze input_idx and all state.
REQ-021 SHALL drive idx_last = BitRev_enable & (input_idx == N-1).
REQ-022 SHALL enter DONE at the first edge where idx_last=1.
REQ-023 SHALL have input_idx never exceed N-1 and never wrap to 0 within a sweep.
REQ-024 SHALL, in DONE, drive done=1 and BitRev_enable=0, return to IDLE after one cycle and clear input_idx to 0.
REQ-025 SHALL ignore start in RUN and DONE with no err pulse.
REQ-026 SHALL have hold no effect in IDLE or DONE.
REQ-027 SHALL, when W=D_WIDTH, produce indices 0..2^D_WIDTH-1, with the terminal compare done at full width and no overflow.
REQ-028 SHALL drive busy = (state==RUN).
REQ-029 SHALL have all outputs registered or decoded from registered state only, with no combinational path from start or l_in to any output.
REQ-030 SHALL set sweep length N cycles + stall cycles, and make done appear exactly one cycle after the last valid index.

Reset
REQ-031 SHALL, on rst=1 (asynchronous, any state, including mid-sweep), go to IDLE and drive input_idx=0, l=0, BitRev_enable=0, idx_last=0, busy=0, done=0, err=0.
REQ-032 SHALL, after rst deasserts, require a new start to begin a sweep; no sweep resumes.

Verification
REQ-033 SHALL cover: l_in=2, start pulse, hold=0 -> BitRev_enable high 16 consecutive cycles with input_idx 0..15, idx_last with 15, done in the next cycle, busy low afterward.
REQ-034 SHALL cover: l_in=2, hold high for 3 cycles while input_idx=5 -> input_idx stays 5 with BitRev_enable=0, then resumes at 6; total RUN time 19 cycles.
REQ-035 SHALL cover: l_in=0 and then l_in=7 (W=14>12) -> err pulse for one cycle each, no busy, l unchanged.
REQ-036 SHALL cover: start re-asserted at input_idx=8 during an l_in=2 sweep -> no effect, sweep ends at 15 with a single done.
REQ-037 SHALL cover: rst asserted asynchronously at input_idx=9 -> all outputs 0 immediately; a new start with l_in=1 then yields input_idx 0..3.
REQ-038 SHALL cover: l_in=6 (W=12) -> 4096 valid indices ending at 4095, idx_last once, no wrap to 0 while BitRev_enable is high.
